// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the clk27-domain input conditioner.
// Includes the debounce/reset defaults and the counter-width function.
package ossc_in_pkg;

    localparam int CLK27_HZ        = 27_000_000;
    localparam int DEBOUNCE_1MS    = 27000;
    localparam int CPU_RESET_WIDTH = 27;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_pulse_t;

    // Bits needed to hold values 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and conditioned-output bundle of the input conditioner.
// The master drives the raw pins and controls; the slave is the conditioner.
interface input_conditioner_if #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
);
    logic [N_IN-1:0]       in_async;
    logic [N_IN-1:0]       db_bypass;
    logic                  cnt_clr;
    logic [N_IN-1:0]       sync_out;
    logic [N_IN-1:0]       stable_out;
    logic [N_IN-1:0]       rise_pulse;
    logic [N_IN-1:0]       fall_pulse;
    logic [N_IN*CNT_W-1:0] event_cnt;

    modport master (
        output in_async, db_bypass, cnt_clr,
        input  sync_out, stable_out, rise_pulse, fall_pulse, event_cnt
    );

    modport slave (
        input  in_async, db_bypass, cnt_clr,
        output sync_out, stable_out, rise_pulse, fall_pulse, event_cnt
    );
endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioned channel: synchronizer, debounce filter, edge pulses and
// a saturating rise counter.
module debounce_ch
    import ossc_in_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int   CNT_W           = 8,
    parameter logic INIT_BIT        = 1'b0
) (
    input  logic             clk27,
    input  logic             reset_n,
    input  logic             in_async,
    input  logic             db_bypass,
    input  logic             cnt_clr,
    output logic             sync_out,
    output logic             stable_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [DW-1:0]          db_cnt_p1;
    logic [DW-1:0]          db_cnt_nxt;
    logic                   stable_nxt;
    edge_pulse_t            ev_nxt;

    // Stage 0: synchronizer chain
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_async};
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

    // Pulses are derived from the stable-level transition only, so flipping
    // bypass mid-count can never produce a second pulse for one change.
    always_comb begin
        stable_nxt = stable_out;
        db_cnt_nxt = '0;
        if (db_bypass) begin
            stable_nxt = sync_out;
        end else if (sync_out != stable_out) begin
            if (db_cnt_p1 == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable_nxt = sync_out;
            end else begin
                db_cnt_nxt = db_cnt_p1 + DW'(1);
            end
        end
        ev_nxt.rise = stable_nxt & ~stable_out;
        ev_nxt.fall = ~stable_nxt & stable_out;
    end

    // Stage 1: debounce state and edge pulses
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_p1  <= '0;
            stable_out <= INIT_BIT;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            db_cnt_p1  <= db_cnt_nxt;
            stable_out <= stable_nxt;
            rise_pulse <= ev_nxt.rise;
            fall_pulse <= ev_nxt.fall;
        end
    end

    // Stage 2: saturating rise counter, clear wins over a coincident rise
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            event_cnt <= '0;
        end else if (cnt_clr) begin
            event_cnt <= '0;
        end else if (rise_pulse && (event_cnt != '1)) begin
            event_cnt <= event_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions N_IN asynchronous control pins in the clk27 domain and
// produces the stretched CPU reset.
module input_conditioner
    import ossc_in_pkg::*;
#(
    parameter int              N_IN            = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int              CNT_W           = 8,
    parameter int              RST_WIDTH       = CPU_RESET_WIDTH,
    parameter logic [N_IN-1:0] INIT_VAL        = {N_IN{1'b0}}
) (
    input  logic                 clk27,
    input  logic                 reset_n,
    input_conditioner_if.slave   bus,
    output logic                 rst_out_n
);

    localparam int RW = cnt_width(RST_WIDTH);

    logic [N_IN-1:0]       sync_w;
    logic [N_IN-1:0]       stable_w;
    logic [N_IN-1:0]       rise_w;
    logic [N_IN-1:0]       fall_w;
    logic [N_IN*CNT_W-1:0] cnt_w;
    logic [RW-1:0]         rst_cnt;

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .INIT_BIT       (INIT_VAL[i])
        ) u_ch (
            .clk27     (clk27),
            .reset_n   (reset_n),
            .in_async  (bus.in_async[i]),
            .db_bypass (bus.db_bypass[i]),
            .cnt_clr   (bus.cnt_clr),
            .sync_out  (sync_w[i]),
            .stable_out(stable_w[i]),
            .rise_pulse(rise_w[i]),
            .fall_pulse(fall_w[i]),
            .event_cnt (cnt_w[i*CNT_W +: CNT_W])
        );
    end

    assign bus.sync_out   = sync_w;
    assign bus.stable_out = stable_w;
    assign bus.rise_pulse = rise_w;
    assign bus.fall_pulse = fall_w;
    assign bus.event_cnt  = cnt_w;

    // rst_out_n releases on the RST_WIDTH-th edge and then latches high
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt   <= '0;
            rst_out_n <= 1'b0;
        end else if (!rst_out_n) begin
            if (rst_cnt == RW'(RST_WIDTH - 1)) begin
                rst_out_n <= 1'b1;
            end else begin
                rst_cnt <= rst_cnt + RW'(1);
            end
        end
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised successor to the ad-hoc button/IR/HDMI-INT synchronizer flops and CPU reset pulse counter in the top level. It conditions N asynchronous control inputs in the clk27 domain: multi-stage synchronization, per-channel debounce with bypass, and one-cycle rise/fall event pulses. It also keeps saturating per-channel rise counters for the CPU status PIO and generates the stretched CPU reset. It sits between the board pins and the sys/ir_rcv/lat_tester instances.

## Interface
- N_IN, 4, number of conditioned channels (1..16)
- SYNC_STAGES, 2, synchronizer flop count (>=2)
- DEBOUNCE_CYCLES, 27000, consecutive stable cycles required before output changes (>=1; 1 ms at 27 MHz)
- CNT_W, 8, width of each event counter
- RST_WIDTH, 27, cycles rst_out_n is held low after reset release (>=1)
- INIT_VAL, {N_IN{1'b0}}, reset level of sync chain and stable outputs per channel

- clk27  in  1  system clock, 27 MHz
- reset_n  in  1  asynchronous, active-low reset
- in_async  in  N_IN  raw asynchronous pins
- db_bypass  in  N_IN  per-channel debounce bypass, synchronous, quasi-static
- cnt_clr  in  1  synchronous clear of all event counters
- sync_out  out  N_IN  synchronized, undebounced level
- stable_out  out  N_IN  debounced level
- rise_pulse  out  N_IN  one-cycle pulse on stable_out 0->1
- fall_pulse  out  N_IN  one-cycle pulse on stable_out 1->0
- event_cnt  out  N_IN*CNT_W  channel i at [i*CNT_W +: CNT_W], rise count
- rst_out_n  out  1  stretched active-low reset for CPU

## Operation
- Reset values: sync chain = INIT_VAL, sync_out = INIT_VAL, stable_out = INIT_VAL, rise/fall_pulse = 0, event_cnt = 0, debounce counters = 0, reset counter = 0, rst_out_n = 0.
- Synchronizer: SYNC_STAGES-deep shift per channel; sync_out = last stage.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync_out == stable_out: counter <= 0.
  - sync_out != stable_out and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync_out != stable_out and counter == DEBOUNCE_CYCLES-1: stable_out <= sync_out, counter <= 0.
  - Any glitch returning sync_out to stable_out before expiry restarts the count from 0.
- Bypass (db_bypass[i]=1): stable_out <= sync_out every cycle; counter held at 0. Toggling bypass mid-count must not produce a double pulse.
- Pulses: registered; rise_pulse[i] is high exactly in the first cycle stable_out[i] is 1; fall_pulse likewise for 0. Never both high.
- Event counter: increments on rise_pulse, saturates at 2^CNT_W-1 (no wrap). cnt_clr has priority: same-cycle clear and rise gives 0.
- Reset generator: after reset_n deasserts, counter counts clk27 edges; rst_out_n goes 1 on the RST_WIDTH-th edge and stays 1 until next reset_n assertion.
- Reset mid-operation: all state returns to reset values immediately (async), including rst_out_n = 0; no pulse is emitted by reset.

## Timing
- in_async change to sync_out: SYNC_STAGES edges (+metastability uncertainty of 1).
- sync_out change at edge k to stable_out change: edge k+DEBOUNCE_CYCLES; bypass: edge k+1.
- rise/fall_pulse coincident with stable_out change; event_cnt updates one edge later.
- cnt_clr sampled at edge; event_cnt reads 0 after that edge.
- DEBOUNCE_CYCLES = 1 behaves identically to bypass.

## Structure
- Package ossc_in_pkg: default constants (CLK27_HZ, DEBOUNCE_1MS = 27000, CPU_RESET_WIDTH = 27) and a function for counter width.
- Sub-module debounce_ch: one channel (sync chain, debounce counter, stable level, pulses, event counter), generated N_IN times; reset generator stays in the top.

## Test plan
- Reset: hold reset_n low, INIT_VAL=4'b0101 -> stable_out=4'b0101, pulses 0, event_cnt 0, rst_out_n 0; release -> rst_out_n rises on 27th edge.
- Clean edge, DEBOUNCE_CYCLES=8, SYNC_STAGES=2: ch0 0->1 -> sync_out at +2 edges, stable_out and single rise_pulse at +10, event_cnt[0]=1 at +11.
- Bounce: ch1 toggles every 3 cycles for 40 cycles then settles high -> exactly one rise_pulse, 8 cycles after final sync_out edge.
- Bypass: db_bypass[2]=1, 1-cycle glitch -> rise and fall pulses 1 cycle apart, event_cnt[2]=1.
- Saturation/clear: CNT_W=2, 5 rises -> event_cnt=3; cnt_clr coincident with 6th rise -> 0.
- Mid-op reset: assert reset_n during debounce count -> no pulse, counters 0, rst_out_n 0, restart from 0 after release.
